// File: rtl/tracklet_div_pkg.sv
// Shared types and constants for the TrackletCalculator 36s/18s iterative divider.
// Holds the FSM state encoding, default widths, counter width and saturation bounds.
package tracklet_div_pkg;

    localparam int DEF_DIVIDEND_W = 36;
    localparam int DEF_DIVISOR_W  = 18;
    localparam int DEF_QUOT_W     = 18;

    localparam int CNT_W = $clog2(DEF_DIVIDEND_W);

    // Signed saturation bounds of the default quotient width
    localparam logic [DEF_QUOT_W-1:0] QMAX = {1'b0, {(DEF_QUOT_W-1){1'b1}}};
    localparam logic [DEF_QUOT_W-1:0] QMIN = {1'b1, {(DEF_QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/tracklet_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Ports: i_prem partial remainder, i_bit next dividend bit, i_dvs divisor magnitude,
//        o_prem next partial remainder, o_qbit quotient bit produced by this step.
module tracklet_div_step #(
    parameter int DIVISOR_W = 18
) (
    input  logic [DIVISOR_W:0]   i_prem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_dvs,
    output logic [DIVISOR_W:0]   o_prem,
    output logic                 o_qbit
);

    logic [DIVISOR_W+1:0] w_shift;
    logic [DIVISOR_W:0]   w_sub;

    assign w_shift = {i_prem, i_bit};

    // The true difference is always below the divisor, so a narrower
    // subtraction is exact whenever the trial succeeds.
    assign w_sub  = w_shift[DIVISOR_W:0] - {1'b0, i_dvs};
    assign o_qbit = (w_shift >= {2'b00, i_dvs});
    assign o_prem = o_qbit ? w_sub : w_shift[DIVISOR_W:0];

endmodule

// File: rtl/tracklet_calc_div_36s_18s_18.sv
// Iterative signed divider (36s / 18s -> 18s quotient and remainder), ap_ctrl_hs handshake.
// Ports: ap_clk, ap_rst (sync, active-high), ap_start/ap_ready/ap_idle/ap_done handshake,
//        din0 dividend, din1 divisor, quot/rem results, div_by_zero and ovf flags.
module tracklet_calc_div_36s_18s_18
    import tracklet_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter int QUOT_W     = DEF_QUOT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic [QUOT_W-1:0]     quot,
    output logic [QUOT_W-1:0]     rem,
    output logic                  div_by_zero,
    output logic                  ovf
);

    localparam int L_CNT_W = $clog2(DIVIDEND_W);

    localparam logic [L_CNT_W-1:0] L_LAST = L_CNT_W'(DIVIDEND_W - 1);

    localparam logic [QUOT_W-1:0] L_QMAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] L_QMIN = {1'b1, {(QUOT_W-1){1'b0}}};

    // Largest quotient magnitudes representable for each result sign
    localparam logic [DIVIDEND_W-1:0] L_POS_LIM =
        {{(DIVIDEND_W-QUOT_W+1){1'b0}}, {(QUOT_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] L_NEG_LIM =
        {{(DIVIDEND_W-QUOT_W){1'b0}}, 1'b1, {(QUOT_W-1){1'b0}}};

    state_t                r_state;
    logic [L_CNT_W-1:0]    r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W:0]    r_prem;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic                  r_neg_n;
    logic                  r_neg_d;
    logic                  r_dz;
    logic [QUOT_W-1:0]     r_dvd_lo;
    logic [QUOT_W-1:0]     r_quot;
    logic [QUOT_W-1:0]     r_rem;
    logic                  r_dz_o;
    logic                  r_ovf;
    logic                  r_done;

    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dvs_mag;
    logic [DIVISOR_W:0]    w_prem_nxt;
    logic                  w_qbit;
    logic                  w_qneg;
    logic                  w_ovf;
    logic [QUOT_W-1:0]     w_qlow;
    logic [QUOT_W-1:0]     w_rlow;
    logic [QUOT_W-1:0]     w_quot_fix;
    logic [QUOT_W-1:0]     w_rem_fix;

    assign ap_idle     = (r_state == IDLE);
    assign ap_ready    = (r_state == IDLE) & ap_start & ~ap_rst;
    assign ap_done     = r_done;
    assign quot        = r_quot;
    assign rem         = r_rem;
    assign div_by_zero = r_dz_o;
    assign ovf         = r_ovf;

    // Unsigned magnitudes; the most negative values still fit unsigned
    assign w_dvd_mag = din0[DIVIDEND_W-1] ? (-din0) : din0;
    assign w_dvs_mag = din1[DIVISOR_W-1] ? (-din1) : din1;

    tracklet_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_prem (r_prem),
        .i_bit  (r_dvd[DIVIDEND_W-1]),
        .i_dvs  (r_dvs),
        .o_prem (w_prem_nxt),
        .o_qbit (w_qbit)
    );

    // After CALC, r_dvd holds the quotient magnitude and r_prem the
    // remainder magnitude.
    assign w_qneg = r_neg_n ^ r_neg_d;
    assign w_ovf  = w_qneg ? (r_dvd > L_NEG_LIM) : (r_dvd > L_POS_LIM);
    assign w_qlow = r_dvd[QUOT_W-1:0];
    assign w_rlow = QUOT_W'(r_prem[DIVISOR_W-1:0]);

    always_comb begin
        w_quot_fix = w_qneg ? (-w_qlow) : w_qlow;
        w_rem_fix  = r_neg_n ? (-w_rlow) : w_rlow;
        if (r_dz) begin
            w_quot_fix = r_neg_n ? L_QMIN : L_QMAX;
            w_rem_fix  = r_dvd_lo;
        end else if (w_ovf) begin
            w_quot_fix = w_qneg ? L_QMIN : L_QMAX;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_prem   <= '0;
            r_dvs    <= '0;
            r_neg_n  <= 1'b0;
            r_neg_d  <= 1'b0;
            r_dz     <= 1'b0;
            r_dvd_lo <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dz_o   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (ap_start) begin
                        r_state  <= CALC;
                        r_cnt    <= '0;
                        r_dvd    <= w_dvd_mag;
                        r_prem   <= '0;
                        r_dvs    <= w_dvs_mag;
                        r_neg_n  <= din0[DIVIDEND_W-1];
                        r_neg_d  <= din1[DIVISOR_W-1];
                        r_dz     <= (din1 == '0);
                        r_dvd_lo <= din0[QUOT_W-1:0];
                    end
                end
                CALC: begin
                    // Dividend bits leave at the top, quotient bits enter at the bottom
                    r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_qbit};
                    r_prem <= w_prem_nxt;
                    if (r_cnt == L_LAST) begin
                        r_cnt   <= '0;
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt + L_CNT_W'(1);
                    end
                end
                FIX: begin
                    r_quot  <= w_quot_fix;
                    r_rem   <= w_rem_fix;
                    r_dz_o  <= r_dz;
                    r_ovf   <= w_ovf & ~r_dz;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tracklet_calc_div_36s_18s_18.sv
// Self-checking bench for the 36s/18s iterative divider.
// Directed cases, handshake/latency/reset checks and random operands against a C-style model.
module tb_tracklet_calc_div_36s_18s_18;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic [35:0] din0;
    logic [17:0] din1;
    logic [17:0] quot;
    logic [17:0] rem;
    logic        div_by_zero;
    logic        ovf;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 ap_clk = ~ap_clk;

    tracklet_calc_div_36s_18s_18 dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .din0        (din0),
        .din1        (din1),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .ovf         (ovf)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // C semantics: truncating division, remainder follows the dividend
    task automatic model(input longint a, input longint b,
                         output longint q, output longint r,
                         output bit dz, output bit ov);
        dz = (b == 0);
        ov = 1'b0;
        if (dz) begin
            q = (a >= 0) ? 131071 : -131072;
            r = (a <<< 46) >>> 46;
        end else begin
            q = a / b;
            r = a % b;
            if (q > 131071) begin
                q  = 131071;
                ov = 1'b1;
            end else if (q < -131072) begin
                q  = -131072;
                ov = 1'b1;
            end
        end
    endtask

    task automatic run_op(input longint a, input longint b,
                          output longint q, output longint r,
                          output bit dz, output bit ov,
                          output int lat, output bit rdy);
        @(negedge ap_clk);
        din0     = a[35:0];
        din1     = b[17:0];
        ap_start = 1'b1;
        #1;
        rdy = ap_ready;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        din0     = ~din0;
        din1     = 18'($urandom);
        lat = 0;
        do begin
            @(negedge ap_clk);
            lat++;
        end while (!ap_done && lat < 100);
        q  = $signed(quot);
        r  = $signed(rem);
        dz = div_by_zero;
        ov = ovf;
    endtask

    task automatic dir_op(input string tag, input longint a, input longint b,
                          input longint eq, input longint er,
                          input bit edz, input bit eov);
        longint q, r;
        bit     dz, ov, rdy;
        int     lat;
        run_op(a, b, q, r, dz, ov, lat, rdy);
        chk({tag, ".ready"}, 64'(rdy), 1);
        chk({tag, ".lat"}, lat, 38);
        chk({tag, ".quot"}, q, eq);
        chk({tag, ".rem"}, r, er);
        chk({tag, ".dz"}, 64'(dz), 64'(edz));
        chk({tag, ".ovf"}, 64'(ov), 64'(eov));
    endtask

    initial begin
        longint a, b, x, y, q, r, mq, mr;
        bit     dz, ov, mdz, mov, rdy;
        int     lat, nd;

        // Reset held together with a start request: nothing is accepted
        ap_rst   = 1'b1;
        ap_start = 1'b1;
        din0     = 36'd1000;
        din1     = 18'd7;
        repeat (3) @(negedge ap_clk);
        #1;
        chk("rst.ready", 64'(ap_ready), 0);
        @(negedge ap_clk);
        ap_rst   = 1'b0;
        ap_start = 1'b0;
        #1;
        chk("rst.idle", 64'(ap_idle), 1);
        chk("rst.done", 64'(ap_done), 0);
        chk("rst.quot", 64'(quot), 0);
        chk("rst.rem", 64'(rem), 0);
        chk("rst.dz", 64'(div_by_zero), 0);
        chk("rst.ovf", 64'(ovf), 0);

        // Directed cases
        dir_op("p_p", 1000, 7, 142, 6, 0, 0);
        dir_op("n_p", -1000, 7, -142, -6, 0, 0);
        dir_op("p_n", 1000, -7, -142, 6, 0, 0);
        dir_op("n_n", -1000, -7, 142, -6, 0, 0);
        dir_op("dz_p", 5, 0, 131071, 5, 1, 0);
        dir_op("dz_n", -5, 0, -131072, -5, 1, 0);
        dir_op("ovf_p", 64'sd1 <<< 30, 1, 131071, 0, 0, 1);
        dir_op("qmin", -131072, 1, -131072, 0, 0, 0);
        dir_op("ovf_mm", -(64'sd1 <<< 35), -131072, 131071, 0, 0, 1);

        // ap_start held high: one acceptance per 39 cycles, late operand changes ignored
        @(negedge ap_clk);
        din0     = 36'd1000;
        din1     = 18'd7;
        ap_start = 1'b1;
        #1;
        chk("hold.ready0", 64'(ap_ready), 1);
        @(posedge ap_clk);
        #1;
        din0 = -36'sd5;
        din1 = 18'd0;
        lat = 0;
        do begin
            @(negedge ap_clk);
            lat++;
        end while (!ap_done && lat < 100);
        chk("hold.lat", lat, 38);
        chk("hold.quot", $signed(quot), 142);
        chk("hold.rem", $signed(rem), 6);
        @(negedge ap_clk);
        #1;
        chk("hold.done_pulse", 64'(ap_done), 0);
        chk("hold.ready39", 64'(ap_ready), 1);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        lat = 0;
        do begin
            @(negedge ap_clk);
            lat++;
        end while (!ap_done && lat < 100);
        chk("hold2.lat", lat, 38);
        chk("hold2.quot", $signed(quot), -131072);
        chk("hold2.rem", $signed(rem), -5);
        chk("hold2.dz", 64'(div_by_zero), 1);

        // Reset on the 10th CALC cycle aborts the operation silently
        @(negedge ap_clk);
        din0     = -36'sd1000;
        din1     = 18'd7;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (10) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        chk("abort.idle", 64'(ap_idle), 1);
        chk("abort.done", 64'(ap_done), 0);
        chk("abort.quot", 64'(quot), 0);
        chk("abort.rem", 64'(rem), 0);
        chk("abort.dz", 64'(div_by_zero), 0);
        ap_rst = 1'b0;
        nd = 0;
        repeat (60) begin
            @(negedge ap_clk);
            if (ap_done) nd++;
        end
        chk("abort.no_done", nd, 0);
        dir_op("after", 1000, 7, 142, 6, 0, 0);

        // Random operands across a spread of magnitudes
        for (int i = 0; i < 1500; i++) begin
            x = {$urandom(), $urandom()};
            a = ((x <<< 28) >>> 28) >>> $urandom_range(0, 35);
            y = longint'($urandom());
            b = ((y <<< 46) >>> 46) >>> $urandom_range(0, 17);
            if ($urandom_range(0, 49) == 0) b = 0;
            model(a, b, mq, mr, mdz, mov);
            run_op(a, b, q, r, dz, ov, lat, rdy);
            chk("rnd.lat", lat, 38);
            chk("rnd.quot", q, mq);
            chk("rnd.rem", r, mr);
            chk("rnd.flags", 64'({dz, ov}), 64'({mdz, mov}));
            if (!mdz && !mov) chk("rnd.inv", a, q * b + r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
